// File: rtl/mio_bus_arb_pkg.sv
// Shared types and constants for the CPU/device memory bus arbiter.
package mio_bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic GRANT_CPU = 1'b0;
   localparam logic GRANT_DEV = 1'b1;

   localparam int unsigned MEM_LAT_MIN = 1;
   localparam int unsigned MEM_LAT_MAX = 15;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned DATA_W      = 32;

endpackage

// File: rtl/mio_lat_cnt.sv
// Loadable down-counter that times one memory access; zero_c marks the last cycle.
module mio_lat_cnt
   import mio_bus_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mio_bus_arb.sv
// Two-requester (CPU / device) round-robin arbiter onto a fixed-latency memory port.
module mio_bus_arb
   import mio_bus_arb_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   input  logic              dev_req,
   input  logic              dev_we,
   input  logic [DATA_W-1:0] dev_addr,
   input  logic [DATA_W-1:0] dev_wdata,
   output logic [DATA_W-1:0] dev_rdata,
   output logic              dev_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              grant,
   output logic [1:0]        state
);

   // Out-of-range latencies are clamped to the supported window.
   localparam int unsigned LAT_C = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                                   (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dev_rdata_q, dev_rdata_d;
   logic              cpu_ready_q, cpu_ready_d;
   logic              dev_ready_q, dev_ready_d;
   logic              cnt_load_c, cnt_dec_c, cnt_zero_c;
   logic              pick_dev_c;

   mio_lat_cnt u_lat_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load_c),
      .dec      (cnt_dec_c),
      .load_val (CNT_W'(LAT_C - 1)),
      .zero_c   (cnt_zero_c)
   );

   // Device wins when alone, or on a tie when the CPU was served last.
   assign pick_dev_c = dev_req & (~cpu_req | (last_q == GRANT_CPU));

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dev_rdata_d = dev_rdata_q;
      cpu_ready_d = 1'b0;
      dev_ready_d = 1'b0;
      cnt_load_c  = 1'b0;
      cnt_dec_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
            if (cpu_req || dev_req) begin
               state_d     = ST_BUSY;
               grant_d     = pick_dev_c ? GRANT_DEV : GRANT_CPU;
               last_d      = pick_dev_c ? GRANT_DEV : GRANT_CPU;
               mem_en_d    = 1'b1;
               mem_we_d    = pick_dev_c ? dev_we    : cpu_we;
               mem_addr_d  = pick_dev_c ? dev_addr  : cpu_addr;
               mem_wdata_d = pick_dev_c ? dev_wdata : cpu_wdata;
               cnt_load_c  = 1'b1;
            end
         end
         ST_BUSY: begin
            if (cnt_zero_c) begin
               state_d  = ST_DONE;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               if (grant_q == GRANT_DEV) begin
                  dev_ready_d = 1'b1;
                  if (!mem_we_q) dev_rdata_d = mem_rdata;
               end else begin
                  cpu_ready_d = 1'b1;
                  if (!mem_we_q) cpu_rdata_d = mem_rdata;
               end
            end else begin
               cnt_dec_c = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= GRANT_CPU;
         last_q      <= GRANT_DEV;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dev_rdata_q <= '0;
         cpu_ready_q <= 1'b0;
         dev_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dev_rdata_q <= dev_rdata_d;
         cpu_ready_q <= cpu_ready_d;
         dev_ready_q <= dev_ready_d;
      end
   end

   assign state     = state_q;
   assign grant     = grant_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dev_rdata = dev_rdata_q;
   assign cpu_ready = cpu_ready_q;
   assign dev_ready = dev_ready_q;

endmodule

// File: tb/tb_mio_bus_arb.sv
// Directed bench for mio_bus_arb: vector table at MEM_LAT=2 plus reset, tie and latency sequences.
module tb_mio_bus_arb;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we, dev_req, dev_we;
   logic [31:0] cpu_addr, cpu_wdata, dev_addr, dev_wdata, mem_rdata;

   logic [31:0] cpu_rdata_o [3];
   logic [31:0] dev_rdata_o [3];
   logic [31:0] mem_addr_o  [3];
   logic [31:0] mem_wdata_o [3];
   logic        cpu_ready_o [3];
   logic        dev_ready_o [3];
   logic        mem_en_o    [3];
   logic        mem_we_o    [3];
   logic        grant_o     [3];
   logic [1:0]  state_o     [3];

   // Instance 0 uses MEM_LAT=2, instance 1 MEM_LAT=1, instance 2 MEM_LAT=15.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      mio_bus_arb #(.MEM_LAT(LAT)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .cpu_req   (cpu_req),
         .cpu_we    (cpu_we),
         .cpu_addr  (cpu_addr),
         .cpu_wdata (cpu_wdata),
         .cpu_rdata (cpu_rdata_o[g]),
         .cpu_ready (cpu_ready_o[g]),
         .dev_req   (dev_req),
         .dev_we    (dev_we),
         .dev_addr  (dev_addr),
         .dev_wdata (dev_wdata),
         .dev_rdata (dev_rdata_o[g]),
         .dev_ready (dev_ready_o[g]),
         .mem_en    (mem_en_o[g]),
         .mem_we    (mem_we_o[g]),
         .mem_addr  (mem_addr_o[g]),
         .mem_wdata (mem_wdata_o[g]),
         .mem_rdata (mem_rdata),
         .grant     (grant_o[g]),
         .state     (state_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        creq, cwe;
      logic [31:0] caddr, cwd;
      logic        dreq, dwe;
      logic [31:0] daddr, dwd, mrd;
      logic [1:0]  st;
      logic        en, we;
      logic [31:0] addr, wd;
      logic        crdy, drdy, gnt;
      logic [31:0] crd, drd;
   } vec_t;

   vec_t vq[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic creq, input logic cwe, input logic [31:0] caddr,
                          input logic [31:0] cwd, input logic dreq, input logic dwe,
                          input logic [31:0] daddr, input logic [31:0] dwd, input logic [31:0] mrd,
                          input logic [1:0] st, input logic en, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd, input logic crdy,
                          input logic drdy, input logic gnt, input logic [31:0] crd,
                          input logic [31:0] drd);
      vec_t v;
      v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
      v.st = st; v.en = en; v.we = we; v.addr = addr; v.wd = wd;
      v.crdy = crdy; v.drdy = drdy; v.gnt = gnt; v.crd = crd; v.drd = drd;
      vq.push_back(v);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".state"}, 32'(state_o[0]), 32'h0);
      check({tag, ".mem_en"}, 32'(mem_en_o[0]), 32'h0);
      check({tag, ".mem_we"}, 32'(mem_we_o[0]), 32'h0);
      check({tag, ".mem_addr"}, mem_addr_o[0], 32'h0);
      check({tag, ".mem_wdata"}, mem_wdata_o[0], 32'h0);
      check({tag, ".cpu_ready"}, 32'(cpu_ready_o[0]), 32'h0);
      check({tag, ".dev_ready"}, 32'(dev_ready_o[0]), 32'h0);
      check({tag, ".grant"}, 32'(grant_o[0]), 32'h0);
      check({tag, ".cpu_rdata"}, cpu_rdata_o[0], 32'h0);
      check({tag, ".dev_rdata"}, dev_rdata_o[0], 32'h0);
   endtask

   // who: 0 = cpu_ready seen, 1 = dev_ready seen, -1 = none within the budget
   task automatic wait_ready(output int who);
      who = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (cpu_ready_o[0]) begin who = 0; break; end
         if (dev_ready_o[0]) begin who = 1; break; end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int who;
      int rdy_seen;
      int en_cnt [3];
      int rdy_at [3];
      int rdy_n  [3];
      int lat    [3];
      lat[0] = 2; lat[1] = 1; lat[2] = 15;

      reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;
      mem_rdata = '0;

      // creq cwe caddr cwd | dreq dwe daddr dwd | mrd || st en we addr wd crdy drdy gnt crd drd
      add_vec(1'b1,1'b0,32'hC,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hAD090000, 2'd1,1'b1,1'b0,32'hC,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0);
      add_vec(1'b1,1'b0,32'hC,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hAD090000, 2'd1,1'b1,1'b0,32'hC,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0);
      add_vec(1'b1,1'b0,32'hC,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hAD090000, 2'd2,1'b0,1'b0,32'hC,32'h0,1'b1,1'b0,1'b0,32'hAD090000,32'h0);
      add_vec(1'b0,1'b0,32'hC,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hAD090000, 2'd0,1'b0,1'b0,32'hC,32'h0,1'b0,1'b0,1'b0,32'hAD090000,32'h0);
      add_vec(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h4,32'h12345678, 32'hAD090000, 2'd1,1'b1,1'b1,32'h4,32'h12345678,1'b0,1'b0,1'b1,32'hAD090000,32'h0);
      add_vec(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h4,32'h12345678, 32'hAD090000, 2'd1,1'b1,1'b1,32'h4,32'h12345678,1'b0,1'b0,1'b1,32'hAD090000,32'h0);
      add_vec(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h4,32'h12345678, 32'hAD090000, 2'd2,1'b0,1'b0,32'h4,32'h12345678,1'b0,1'b1,1'b1,32'hAD090000,32'h0);
      add_vec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b1,32'h4,32'h12345678, 32'hAD090000, 2'd0,1'b0,1'b0,32'h4,32'h12345678,1'b0,1'b0,1'b1,32'hAD090000,32'h0);
      add_vec(1'b1,1'b0,32'h8,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h11111111, 2'd1,1'b1,1'b0,32'h8,32'h0,1'b0,1'b0,1'b0,32'hAD090000,32'h0);
      add_vec(1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0, 32'h11111111, 2'd1,1'b1,1'b0,32'h8,32'h0,1'b0,1'b0,1'b0,32'hAD090000,32'h0);
      add_vec(1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0, 32'h22222222, 2'd2,1'b0,1'b0,32'h8,32'h0,1'b1,1'b0,1'b0,32'h22222222,32'h0);
      add_vec(1'b0,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h22222222, 2'd0,1'b0,1'b0,32'h8,32'h0,1'b0,1'b0,1'b0,32'h22222222,32'h0);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h33333333, 2'd1,1'b1,1'b0,32'h200,32'h0,1'b0,1'b0,1'b1,32'h22222222,32'h0);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h33333333, 2'd1,1'b1,1'b0,32'h200,32'h0,1'b0,1'b0,1'b1,32'h22222222,32'h0);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h33333333, 2'd2,1'b0,1'b0,32'h200,32'h0,1'b0,1'b1,1'b1,32'h22222222,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h33333333, 2'd0,1'b0,1'b0,32'h200,32'h0,1'b0,1'b0,1'b1,32'h22222222,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h44444444, 2'd1,1'b1,1'b0,32'h100,32'h0,1'b0,1'b0,1'b0,32'h22222222,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h44444444, 2'd1,1'b1,1'b0,32'h100,32'h0,1'b0,1'b0,1'b0,32'h22222222,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h44444444, 2'd2,1'b0,1'b0,32'h100,32'h0,1'b1,1'b0,1'b0,32'h44444444,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h44444444, 2'd0,1'b0,1'b0,32'h100,32'h0,1'b0,1'b0,1'b0,32'h44444444,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h55555555, 2'd1,1'b1,1'b0,32'h200,32'h0,1'b0,1'b0,1'b1,32'h44444444,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h55555555, 2'd1,1'b1,1'b0,32'h200,32'h0,1'b0,1'b0,1'b1,32'h44444444,32'h33333333);
      add_vec(1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,32'h200,32'h0, 32'h55555555, 2'd2,1'b0,1'b0,32'h200,32'h0,1'b0,1'b1,1'b1,32'h44444444,32'h55555555);
      add_vec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0, 2'd0,1'b0,1'b0,32'h200,32'h0,1'b0,1'b0,1'b1,32'h44444444,32'h55555555);
      add_vec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0, 2'd0,1'b0,1'b0,32'h200,32'h0,1'b0,1'b0,1'b1,32'h44444444,32'h55555555);

      // Reset values while reset is held
      tick();
      tick();
      check_zero("rst");
      reset = 1'b1;

      foreach (vq[i]) begin
         cpu_req = vq[i].creq; cpu_we = vq[i].cwe; cpu_addr = vq[i].caddr; cpu_wdata = vq[i].cwd;
         dev_req = vq[i].dreq; dev_we = vq[i].dwe; dev_addr = vq[i].daddr; dev_wdata = vq[i].dwd;
         mem_rdata = vq[i].mrd;
         tick();
         check($sformatf("v%0d.state", i), 32'(state_o[0]), 32'(vq[i].st));
         check($sformatf("v%0d.mem_en", i), 32'(mem_en_o[0]), 32'(vq[i].en));
         check($sformatf("v%0d.mem_we", i), 32'(mem_we_o[0]), 32'(vq[i].we));
         check($sformatf("v%0d.mem_addr", i), mem_addr_o[0], vq[i].addr);
         check($sformatf("v%0d.mem_wdata", i), mem_wdata_o[0], vq[i].wd);
         check($sformatf("v%0d.cpu_ready", i), 32'(cpu_ready_o[0]), 32'(vq[i].crdy));
         check($sformatf("v%0d.dev_ready", i), 32'(dev_ready_o[0]), 32'(vq[i].drdy));
         check($sformatf("v%0d.grant", i), 32'(grant_o[0]), 32'(vq[i].gnt));
         check($sformatf("v%0d.cpu_rdata", i), cpu_rdata_o[0], vq[i].crd);
         check($sformatf("v%0d.dev_rdata", i), dev_rdata_o[0], vq[i].drd);
      end

      // Reset in the second BUSY cycle aborts the access
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8; mem_rdata = 32'h66666666;
      tick();
      check("abort.busy1", 32'(state_o[0]), 32'd1);
      tick();
      reset = 1'b0;
      #1;
      check_zero("abort");
      cpu_req = 1'b0;
      tick();
      reset = 1'b1;
      rdy_seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (cpu_ready_o[0] || dev_ready_o[0] || state_o[0] != 2'd0) rdy_seen++;
      end
      check("abort.no_ready", 32'(rdy_seen), 32'd0);

      // Tie right after reset: CPU first, then alternation while both are held
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h30;
      mem_rdata = 32'h0BADF00D;
      wait_ready(who);
      check("tie.first", 32'(who), 32'd0);
      check("tie.cpu_rdata", cpu_rdata_o[0], 32'h0BADF00D);
      wait_ready(who);
      check("tie.second", 32'(who), 32'd1);
      wait_ready(who);
      check("tie.third", 32'(who), 32'd0);
      cpu_req = 1'b0; dev_req = 1'b0;
      for (int k = 0; k < 20; k++) tick();

      // Latency: one-cycle CPU read request seen by all three instances
      for (int g = 0; g < 3; g++) begin en_cnt[g] = 0; rdy_at[g] = 0; rdy_n[g] = 0; end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; mem_rdata = 32'h77;
      tick();
      cpu_req = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         for (int g = 0; g < 3; g++) begin
            if (mem_en_o[g]) en_cnt[g]++;
            if (cpu_ready_o[g]) begin rdy_n[g]++; rdy_at[g] = k; end
         end
         tick();
      end
      for (int g = 0; g < 3; g++) begin
         check($sformatf("lat%0d.en_width", lat[g]), 32'(en_cnt[g]), 32'(lat[g]));
         check($sformatf("lat%0d.ready_cycle", lat[g]), 32'(rdy_at[g]), 32'(lat[g] + 1));
         check($sformatf("lat%0d.ready_pulses", lat[g]), 32'(rdy_n[g]), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
